// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: segment patterns {a..g}, a = MSB,
// and a one-hot helper.
package seg_pkg;

    localparam int unsigned SEG_W    = 7;
    localparam int unsigned ONEHOT_W = 32;

    localparam logic [SEG_W-1:0] SEG_0   = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A   = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B   = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C   = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D   = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F   = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

    // Callers truncate to their own enable width.
    function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned i);
        return ONEHOT_W'(1) << i;
    endfunction

endpackage

// File: rtl/hex7_lut.sv
// Combinational hex nibble to 7-segment pattern lookup.
module hex7_lut
    import seg_pkg::*;
(
    input  logic [3:0]       nib,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-aligned load/ack update.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4*DIGITS-1:0] value,
    input  logic                load,
    output logic                ack,
    output logic [SEG_W-1:0]    seg,
    output logic [DIGITS-1:0]   digit_en
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned VW = 4 * DIGITS;

    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic             tick;
    logic             frame_end;
    logic [VW-1:0]    staging;
    logic [VW-1:0]    shadow;
    logic             pending;
    logic [3:0]       nib;
    logic [SEG_W-1:0] lut_seg;
    logic [DIGITS-1:0] blank;

    assign tick      = (cnt == CW'(DIV - 1));
    assign frame_end = tick && (idx == IW'(DIGITS - 1));

    // Digit slot prescaler and scan index.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= frame_end ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Staging/shadow handshake; a load coinciding with the boundary bypasses staging.
    always_ff @(posedge clk) begin
        if (rst) begin
            staging <= '0;
            shadow  <= '0;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (load) begin
                staging <= value;
            end
            if (frame_end && pending) begin
                shadow  <= load ? value : staging;
                pending <= 1'b0;
                ack     <= 1'b1;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_LZB_EN
    logic seen;

    // Blank every digit above the most significant nonzero nibble; digit 0 always shows.
    always_comb begin
        blank = '0;
        seen  = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            if (shadow[4*k +: 4] != 4'h0) begin
                seen = 1'b1;
            end
            blank[k] = !seen;
        end
    end
`else
    assign blank = '0;
`endif

    assign nib = shadow[{idx, 2'b00} +: 4];

    hex7_lut u_lut (
        .nib (nib),
        .seg (lut_seg)
    );

    // Registered pin drive; the tick cycle is the dead slot between digits.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg      <= SEG_OFF;
            digit_en <= '0;
        end else if (tick) begin
            seg      <= SEG_OFF;
            digit_en <= '0;
        end else begin
            digit_en <= DIGITS'(onehot(32'(idx)));
            seg      <= blank[idx] ? SEG_OFF : lut_seg;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIGITS=4, DIV=4; define SEG_SCAN_LZB_EN to check blanking.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  digit_en;

    int errors = 0;
    int checks = 0;
    int n = -1;

    localparam logic [6:0] LUT [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    seg_scan_ctrl #(.DIGITS(4), .DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .load     (load),
        .ack      (ack),
        .seg      (seg),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected segments for observation n (cycle n of the scan) given the displayed value.
    function automatic logic [6:0] exp_seg(input int cyc, input logic [15:0] shw);
        int c = cyc % 4;
        int i = (cyc / 4) % 4;
        logic [15:0] hi;
        logic [3:0]  nb;
        if (c == 3) return 7'b0;
        hi = shw >> (4 * i);
        nb = hi[3:0];
`ifdef SEG_SCAN_LZB_EN
        if (i > 0 && hi == 16'h0) return 7'b0;
`endif
        return LUT[nb];
    endfunction

    function automatic logic [3:0] exp_en(input int cyc);
        int c = cyc % 4;
        int i = (cyc / 4) % 4;
        logic [3:0] one = 4'b0001;
        if (c == 3) return 4'b0000;
        return one << i;
    endfunction

    task automatic run(input int cycles, input logic [15:0] shw, input int ack_at);
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            n++;
            check($sformatf("seg@%0d", n), 32'(seg), 32'(exp_seg(n, shw)));
            check($sformatf("en@%0d", n), 32'(digit_en), 32'(exp_en(n)));
            check($sformatf("ack@%0d", n), 32'(ack), 32'(n == ack_at));
            load = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        load = 1'b0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            check("rst_seg", 32'(seg), 32'h0);
            check("rst_en", 32'(digit_en), 32'h0);
            check("rst_ack", 32'(ack), 32'h0);
        end
        rst = 1'b0;
        n = -1;
    endtask

    task automatic pulse_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
    endtask

    initial begin
        // Power-up: digit 0 shows "0" in the first cycle after release.
        do_reset(3);
        run(3, 16'h0000, -1);

        // Scan order over two full frames.
        pulse_load(16'h1234);
        run(13, 16'h0000, 15);
        run(32, 16'h1234, -1);

        // Tear-free update: second load overwrites staging, one ack.
        pulse_load(16'hAAAA);
        run(6, 16'h1234, -1);
        pulse_load(16'hFFFF);
        run(10, 16'h1234, 63);
        run(16, 16'hFFFF, -1);

        // Load coinciding with frame_end while pending goes straight to shadow.
        pulse_load(16'h1111);
        run(15, 16'hFFFF, -1);
        pulse_load(16'h00C0);
        run(1, 16'hFFFF, 95);
        run(16, 16'h00C0, -1);

        // Values with leading zeros (blanked only when the option is built in).
        pulse_load(16'h0050);
        run(16, 16'h00C0, 127);
        run(16, 16'h0050, -1);
        pulse_load(16'h0000);
        run(16, 16'h0050, 159);
        run(16, 16'h0000, -1);

        // Reset while pending discards the staged value and produces no ack.
        pulse_load(16'h9999);
        run(5, 16'h0000, -1);
        do_reset(2);
        run(32, 16'h0000, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for a common multi-digit 7-segment display. Holds a DIGITS-wide packed hex value, cycles one digit at a time through a single internal hex-to-segment decoder and drives one-hot digit enables with a dead cycle between digits to prevent ghosting. New values are accepted through a load/ack handshake and applied only at a frame boundary, so a frame never mixes old and new digits. Sits between the counter/arithmetic logic and the board's segment and digit-enable pins.

## Interface
- DIGITS, 4: number of digits scanned; minimum 1.
- DIV, 50000: clock cycles per digit slot, dead cycle included; minimum 2.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- value  in  4*DIGITS  packed hex digits; nibble k = digit k, digit 0 least significant.
- load  in  1  one-cycle request to display `value`.
- ack  out  1  one-cycle pulse: staged value now in the display shadow.
- seg  out  7  active-high segments {a,b,c,d,e,f,g}, a = MSB.
- digit_en  out  DIGITS  one-hot active-high digit enable; all-zero during dead cycles.

## Operation
- Prescaler `cnt` counts 0..DIV-1 and wraps. `tick = (cnt == DIV-1)`.
- Scan index `idx` advances on `tick` and wraps DIGITS-1 -> 0. `frame_end = tick && idx == DIGITS-1`.
- Registers: `staging`, `pending`, `shadow`.
  - `load` writes `value` into `staging` and sets `pending`.
  - A repeated `load` while `pending` overwrites `staging`; the latest value wins and only one `ack` is issued.
- At `frame_end` with `pending` set:
  - `shadow` <= `staging` and `pending` clears.
  - If `load` arrives in the same cycle, the `value` presented in that cycle goes straight into `shadow`, and `pending` ends clear.
- At `frame_end` without `pending`: `shadow` is unchanged and no `ack` is issued.
- Decoding: hex 0..F maps to the standard patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.

## Timing
- Reset values: all outputs are 0. `cnt`, `idx`, `staging`, `shadow`, `pending` and `ack` are all 0.
- Outputs are registered and updated every cycle:
  - In a `tick` cycle: `digit_en` <= 0 and `seg` <= 0 (the dead cycle).
  - Otherwise: `digit_en` <= onehot(idx) and `seg` <= decode(shadow[idx]), or 0 if the digit is blanked.
- After reset release:
  - First cycle: `digit_en = 0...01`, `seg = 1111110`.
  - Each digit is lit for DIV-1 cycles, followed by one dead cycle.
- Frame period is DIGITS*DIV cycles.
- `ack` rises in the cycle after `frame_end` and is high for exactly one cycle.
- Latency from `load` to display depends on scan position:
  - Worst case: DIGITS*DIV cycles until `frame_end`, then 1 more cycle.
  - Digit 0 of the new value is driven in the first non-dead cycle after that `frame_end`.
- Reset during any phase, including with `pending` set, discards `staging` and produces no `ack`.

## Configuration
- `SEG_SCAN_LZB_EN` (leading-zero blanking):
  - Defined: digits above the most significant nonzero nibble of `shadow` are blanked. A blanked digit drives `seg = 0` while its `digit_en` bit stays one-hot. Digit 0 is never blanked, so a value of 0 shows a single "0". Blank flags are computed from `shadow`, so they change only at frame boundaries.
  - Undefined: all digits always display, leading zeros included.

## Structure
- Shared package `seg_pkg`:
  - 7-bit segment constants for 0..F and `SEG_OFF = 7'b0`.
  - A function returning the one-hot value of an index.
- Sub-module `hex7_lut`: combinational nibble -> 7-bit segment lookup per the decode list above. Instantiated once and fed by the `shadow` nibble mux.
- Prescaler width is $clog2(DIV). Index width is max(1, $clog2(DIGITS)).

## Test plan
All scenarios use DIGITS=4, DIV=4.
- Reset/power-up: hold `rst` 3 cycles, then release.
  - During reset: `seg = 0`, `digit_en = 0000`, `ack = 0`.
  - First cycle after release: `digit_en = 0001`, `seg = 1111110`.
- Scan order: `load` `value = 16'h1234`, then observe two frames after `ack`.
  - Digit sequence 0001(4=0110011), 0010(3=1111001), 0100(2=1101101), 1000(1=0110000).
  - Each digit lit 3 cycles, with one all-zero dead cycle between digits.
- Tear-free update: `load 16'hAAAA`, then `load 16'hFFFF` mid-frame.
  - The current frame stays on the old value.
  - Exactly one `ack`, and the next frame shows all digits F = 1000111.
- Simultaneous `load` and `frame_end`: assert `load` with 16'h00C0 exactly in the `frame_end` cycle.
  - `ack` follows next cycle and the next frame shows C on digit 1.
- Leading-zero blanking, with `SEG_SCAN_LZB_EN` defined: `load 16'h0050`.
  - Digits 3 and 2 are `seg = 0` with `digit_en` still 1000 / 0100.
  - Digit 1 = 1011011, digit 0 = 1111110.
  - With 16'h0000, only digit 0 is lit.
- Reset mid-pending: `load 16'h9999`, then assert `rst` before `frame_end`.
  - No `ack` and `shadow` is 0; after release, digit 0 shows 1111110.
